row_band_loader: RTL and testbench

//  Upstream feeder of the window-shift stage. Accepts a raster pixel stream,
//  row-major, one 8-bit pixel per transfer. Assembles a band of FILTER_SIZE

---
 rtl/row_band_loader.sv | 152 +++++++++++++++
 tb/tb_row_band_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_band_loader.sv
// Collects a raster pixel stream into a FILTER_SIZE-row band for the window-shift stage,
// primes and scans that stage, then slides the band down one image row per returned new_buffer.
module row_band_loader #(
   parameter int IMAGE_WIDTH  = 5,
   parameter int IMAGE_HEIGHT = 5,
   parameter int FILTER_SIZE  = 3
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 pix_valid,
   input  logic [7:0]                           pix_data,
   output logic                                 pix_ready,
   input  logic                                 new_buffer,
   output logic [FILTER_SIZE*IMAGE_WIDTH*8-1:0] row_buffer_out,
   output logic                                 shift_en,
   output logic                                 shift_buffer,
   output logic                                 frame_done
);

   localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int ROW_W = $clog2(IMAGE_HEIGHT + 1);
   localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [COL_W-1:0] COL_ONE       = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_ONE       = ROW_W'(1);
   localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(FILTER_SIZE - 1);
   localparam logic [ROW_W-1:0] ROW_FRAME_END = ROW_W'(IMAGE_HEIGHT);

   typedef enum logic [2:0] {
      S_FILL,
      S_PRIME,
      S_SCAN,
      S_LOAD,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [7:0]         band_q [FILTER_SIZE][IMAGE_WIDTH];
   logic [7:0]         band_d [FILTER_SIZE][IMAGE_WIDTH];
   logic               accept;
   logic               last_col;

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      band_d   = band_q;
      accept   = pix_valid && (state_q == S_FILL || state_q == S_LOAD);
      last_col = (col_q == COL_LAST);

      case (state_q)
         S_FILL: begin
            if (accept) begin
               for (int r = 0; r < FILTER_SIZE; r++) begin
                  for (int c = 0; c < IMAGE_WIDTH; c++) begin
                     if (r == int'(row_q) && c == int'(col_q)) begin
                        band_d[r][c] = pix_data;
                     end
                  end
               end
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + ROW_ONE;
                  if (row_q == ROW_FILL_LAST) begin
                     state_d = S_PRIME;
                  end
               end else begin
                  col_d = col_q + COL_ONE;
               end
            end
         end
         S_PRIME: begin
            state_d = S_SCAN;
         end
         S_SCAN: begin
            if (new_buffer) begin
               if (row_q == ROW_FRAME_END) begin
                  state_d = S_DONE;
               end else begin
                  // Slide the band up so the oldest row drops out; the new row lands at the bottom.
                  state_d = S_LOAD;
                  col_d   = '0;
                  for (int r = 0; r < FILTER_SIZE - 1; r++) begin
                     band_d[r] = band_q[r + 1];
                  end
                  for (int c = 0; c < IMAGE_WIDTH; c++) begin
                     band_d[FILTER_SIZE-1][c] = 8'h00;
                  end
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               for (int c = 0; c < IMAGE_WIDTH; c++) begin
                  if (c == int'(col_q)) begin
                     band_d[FILTER_SIZE-1][c] = pix_data;
                  end
               end
               if (last_col) begin
                  col_d   = '0;
                  row_d   = row_q + ROW_ONE;
                  state_d = S_PRIME;
               end else begin
                  col_d = col_q + COL_ONE;
               end
            end
         end
         S_DONE: begin
            col_d   = '0;
            row_d   = '0;
            state_d = S_FILL;
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FILL;
         col_q   <= '0;
         row_q   <= '0;
         for (int r = 0; r < FILTER_SIZE; r++) begin
            for (int c = 0; c < IMAGE_WIDTH; c++) begin
               band_q[r][c] <= 8'h00;
            end
         end
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         band_q  <= band_d;
      end
   end

   // Handshake outputs are forced low while reset is held, even though the state already reads FILL.
   assign pix_ready    = rst && (state_q == S_FILL || state_q == S_LOAD);
   assign shift_en     = rst && (state_q == S_PRIME);
   assign shift_buffer = rst && (state_q == S_SCAN) && !new_buffer;
   assign frame_done   = (state_q == S_DONE);

   generate
      for (genvar gr = 0; gr < FILTER_SIZE; gr++) begin : g_row
         for (genvar gc = 0; gc < IMAGE_WIDTH; gc++) begin : g_col
            assign row_buffer_out[(gr*IMAGE_WIDTH+gc)*8 +: 8] = band_q[gr][gc];
         end
      end
   endgenerate

endmodule

// File: tb/tb_row_band_loader.sv
// Randomized frame-level bench for row_band_loader: a stream/scan model predicts every output each
// cycle, with literal band values pinned for the 1..25 directed frames and a 3-row-image instance.
module tb_row_band_loader;

   localparam int W  = 5;
   localparam int H  = 5;
   localparam int F  = 3;
   localparam int HB = 3;
   localparam int NB = F * W * 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          pix_valid = 1'b0;
   logic [7:0]    pix_data = 8'h00;
   logic          new_buffer = 1'b0;
   logic          pix_ready;
   logic [NB-1:0] row_buffer_out;
   logic          shift_en;
   logic          shift_buffer;
   logic          frame_done;

   logic          b_pix_valid = 1'b0;
   logic [7:0]    b_pix_data = 8'h00;
   logic          b_new_buffer = 1'b0;
   logic          b_pix_ready;
   logic [NB-1:0] b_row;
   logic          b_shift_en;
   logic          b_shift_buffer;
   logic          b_frame_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   row_band_loader #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FILTER_SIZE(F)) dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .new_buffer(new_buffer), .row_buffer_out(row_buffer_out), .shift_en(shift_en),
      .shift_buffer(shift_buffer), .frame_done(frame_done)
   );

   row_band_loader #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(HB), .FILTER_SIZE(F)) dut_b (
      .clk(clk), .rst(rst), .pix_valid(b_pix_valid), .pix_data(b_pix_data), .pix_ready(b_pix_ready),
      .new_buffer(b_new_buffer), .row_buffer_out(b_row), .shift_en(b_shift_en),
      .shift_buffer(b_shift_buffer), .frame_done(b_frame_done)
   );

   function automatic void check_bit(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void check_int(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void check_band(string name, logic [NB-1:0] act, logic [NB-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Band holding pixels s*W+1 .. s*W+F*W of a frame whose pixels are 1..25.
   function automatic logic [NB-1:0] lit_band(int s);
      logic [NB-1:0] v;
      for (int p = 0; p < F * W; p++) v[p*8 +: 8] = 8'(s * W + p + 1);
      return v;
   endfunction

   // ---------------- behavioural model: frame pixels, scans consumed, protocol phase ----------------
   logic [7:0] frame_pix [H*W];
   logic [7:0] stale [F*W];
   int  acc;
   int  scans;
   bit  m_ready, m_prime, m_scan, m_done;

   // Band = the F*W-pixel window starting at row `scans` of the frame; pixels not yet received are
   // zero once the band has slid, or whatever the previous frame left behind before the first scan.
   function automatic logic [NB-1:0] exp_band();
      logic [NB-1:0] v;
      int idx;
      for (int p = 0; p < F * W; p++) begin
         idx = scans * W + p;
         if (idx < acc)      v[p*8 +: 8] = frame_pix[idx];
         else if (scans > 0) v[p*8 +: 8] = 8'h00;
         else                v[p*8 +: 8] = stale[p];
      end
      return v;
   endfunction

   initial begin
      logic [NB-1:0] tmp;
      acc = 0; scans = 0;
      m_ready = 1'b1; m_prime = 1'b0; m_scan = 1'b0; m_done = 1'b0;
      for (int p = 0; p < F * W; p++) stale[p] = 8'h00;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            acc = 0; scans = 0;
            m_ready = 1'b1; m_prime = 1'b0; m_scan = 1'b0; m_done = 1'b0;
            for (int p = 0; p < F * W; p++) stale[p] = 8'h00;
         end else if (m_ready) begin
            if (pix_valid) begin
               frame_pix[acc] = pix_data;
               acc++;
               if (acc == W * (F + scans)) begin
                  m_ready = 1'b0; m_prime = 1'b1;
               end
            end
         end else if (m_prime) begin
            m_prime = 1'b0; m_scan = 1'b1;
         end else if (m_scan) begin
            if (new_buffer) begin
               m_scan = 1'b0;
               if (scans == H - F) m_done = 1'b1;
               else begin
                  scans++; m_ready = 1'b1;
               end
            end
         end else if (m_done) begin
            tmp = exp_band();
            for (int p = 0; p < F * W; p++) stale[p] = tmp[p*8 +: 8];
            acc = 0; scans = 0;
            m_done = 1'b0; m_ready = 1'b1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check_bit("pix_ready", pix_ready, rst && m_ready);
         check_bit("shift_en", shift_en, rst && m_prime);
         check_bit("shift_buffer", shift_buffer, rst && m_scan && !new_buffer);
         check_bit("frame_done", frame_done, m_done);
         check_bit("en_and_scan_exclusive", shift_en && shift_buffer, 1'b0);
         check_band("band", row_buffer_out, exp_band());
      end
   end

   // ---------------- stimulus ----------------
   // vmode: 0 back-to-back, 1 every other cycle, 2 random gaps. rnd: random pixel values.
   // spur: stray new_buffer pulses while loading. abort_at: reset after that many pixels (-1 none).
   task automatic run_frame(input int vmode, input bit rnd, input bit spur, input int abort_at,
                            input bit nbr);
      logic [7:0] vals [H*W];
      int  idx = 0, sbc = 0, nbt = 3, cyc = 0, primes = 0;
      bit  done = 1'b0, aborted = 1'b0, ready_s;
      for (int i = 0; i < H * W; i++) vals[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1);
      while (!done && cyc < 3000) begin
         @(negedge clk);
         ready_s = pix_ready;
         if (shift_en) begin
            if (!rnd) check_band("prime_band_literal", row_buffer_out, lit_band(primes));
            primes++;
         end
         if (shift_buffer) sbc++;
         if (frame_done) done = 1'b1;
         @(posedge clk);
         if (pix_valid && ready_s) idx++;
         #2;
         if (abort_at >= 0 && idx == abort_at) begin
            aborted = 1'b1;
            break;
         end
         if (sbc >= nbt) begin
            new_buffer = 1'b1;
            sbc = 0;
            nbt = nbr ? int'($urandom_range(1, 5)) : 3;
         end else begin
            new_buffer = spur && ready_s && ($urandom_range(0, 3) == 0);
         end
         case (vmode)
            0:       pix_valid = (idx < H * W);
            1:       pix_valid = (cyc % 2 == 0) && (idx < H * W);
            default: pix_valid = ($urandom_range(0, 2) != 0) && (idx < H * W);
         endcase
         pix_data = (idx < H * W) ? vals[idx] : 8'($urandom_range(0, 255));
         cyc++;
      end
      if (aborted) begin
         rst = 1'b0; pix_valid = 1'b0; new_buffer = 1'b0;
         @(negedge clk);
         check_bit("abort_pix_ready", pix_ready, 1'b0);
         check_bit("abort_shift_en", shift_en, 1'b0);
         check_bit("abort_shift_buffer", shift_buffer, 1'b0);
         check_bit("abort_frame_done", frame_done, 1'b0);
         check_band("abort_band", row_buffer_out, '0);
         @(posedge clk);
         #2 rst = 1'b1;
      end else begin
         check_bit("frame_completed", done, 1'b1);
         check_int("scans_per_frame", primes, H - F + 1);
         pix_valid = 1'b0; new_buffer = 1'b0;
      end
   endtask

   task automatic run_b();
      int  bidx = 0, sbc = 0, se = 0, nbs = 0, cyc = 0;
      bit  done = 1'b0, r;
      @(posedge clk);
      #2 b_pix_valid = 1'b1; b_pix_data = 8'd1;
      while (!done && cyc < 300) begin
         @(negedge clk);
         r = b_pix_ready;
         if (b_shift_en) begin
            se++;
            check_band("b_prime_band", b_row, lit_band(0));
         end
         if (b_shift_buffer) sbc++;
         if (b_frame_done) begin
            done = 1'b1;
            check_band("b_done_band", b_row, lit_band(0));
            check_bit("b_done_ready", r, 1'b0);
         end
         @(posedge clk);
         if (b_pix_valid && r) bidx++;
         #2;
         b_pix_valid  = (bidx < F * W);
         b_pix_data   = 8'(bidx + 1);
         b_new_buffer = (sbc == 3);
         if (sbc == 3) begin
            sbc = 0; nbs++;
         end
         cyc++;
      end
      check_bit("b_frame_completed", done, 1'b1);
      check_int("b_prime_count", se, 1);
      check_int("b_scan_count", nbs, 1);
      b_new_buffer = 1'b0;
      @(negedge clk);
      check_bit("b_after_done_ready", b_pix_ready, 1'b1);
      check_bit("b_after_done_frame_done", b_frame_done, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_bit("reset_pix_ready", pix_ready, 1'b0);
      check_bit("reset_shift_en", shift_en, 1'b0);
      check_bit("reset_shift_buffer", shift_buffer, 1'b0);
      check_bit("reset_frame_done", frame_done, 1'b0);
      check_band("reset_band", row_buffer_out, '0);
      check_bit("reset_b_pix_ready", b_pix_ready, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check_bit("ready_after_reset", pix_ready, 1'b1);

      run_frame(0, 1'b0, 1'b0, -1, 1'b0);
      run_frame(1, 1'b0, 1'b0, -1, 1'b0);
      run_frame(2, 1'b0, 1'b1, -1, 1'b0);
      run_frame(0, 1'b0, 1'b0, 18, 1'b0);
      run_frame(0, 1'b0, 1'b0, -1, 1'b0);
      repeat (6) run_frame(2, 1'b1, 1'b1, -1, 1'b1);
      run_b();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
